// File: rtl/boundary_pkg.sv
// Shared types and constants for the river boundary generator and the boundary memory.
package boundary_pkg;

  localparam int unsigned COL_W    = 10;
  localparam int unsigned ROW_W    = 40;
  localparam int unsigned SCREEN_W = 640;

  localparam int unsigned LEFT_LSB   = 30;
  localparam int unsigned ISL_L_LSB  = 20;
  localparam int unsigned ISL_R_LSB  = 10;
  localparam int unsigned RIGHT_LSB  = 0;

  typedef logic [COL_W-1:0] col_t;

  typedef struct packed {
    col_t left_edge;
    col_t island_left;
    col_t island_right;
    col_t right_edge;
  } row_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StStep,
    StCommit
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam col_t RST_CENTER      = 10'd320;
  localparam col_t RST_HALF        = 10'd200;
  localparam col_t ISLAND_OFS      = 10'd96;
  localparam col_t TGT_CENTER_BASE = 10'd192;
  localparam col_t TGT_HALF_BASE   = 10'd64;

  localparam row_t RST_ROW = '{
    left_edge:    10'd120,
    island_left:  10'd216,
    island_right: 10'd424,
    right_edge:   10'd520
  };

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
    logic fb;
    fb = cur[0] ^ cur[2] ^ cur[3] ^ cur[5];
    return {fb, cur[15:1]};
  endfunction

  function automatic col_t step_toward(input col_t cur, input col_t tgt);
    if (cur < tgt) begin
      return cur + col_t'(1);
    end else if (cur > tgt) begin
      return cur - col_t'(1);
    end
    return cur;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step per cycle with step high.
module lfsr16
  import boundary_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] value_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= LFSR_SEED;
    end else if (step) begin
      value_q <= lfsr16_next(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/boundary_gen.sv
// Generates one river boundary row per accepted scroll tick, drifting the channel
// centre and half-width one pixel per row toward pseudo-random segment targets.
module boundary_gen
  import boundary_pkg::*;
#(
  parameter int unsigned SEG_LEN    = 32,
  parameter int unsigned ISLAND_MIN = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             tick,
  output logic [ROW_W-1:0] datain,
  output logic             shift,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CntW = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;

  state_e state_q, state_d;

  logic        lfsr_step;
  logic [15:0] lfsr_value;
  logic [15:0] lfsr_post;
  logic        unused_lfsr_msb;

  col_t center_q, center_d;
  col_t half_q, half_d;
  col_t tgt_center_q, tgt_center_d;
  col_t tgt_half_q, tgt_half_d;
  col_t ihalf;

  logic [CntW-1:0] seg_cnt_q, seg_cnt_d;

  row_t row_q, row_d;
  logic commit_q;
  logic shift_q;
  logic overrun_q;

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (lfsr_step),
    .value   (lfsr_value)
  );

  // Targets are drawn from the value the LFSR holds after this CALC step.
  assign lfsr_post       = lfsr16_next(lfsr_value);
  assign unused_lfsr_msb = lfsr_post[15];

  assign ihalf = (half_q >= col_t'(ISLAND_MIN)) ? (half_q - ISLAND_OFS) : '0;

  always_comb begin
    state_d      = state_q;
    lfsr_step    = 1'b0;
    center_d     = center_q;
    half_d       = half_q;
    tgt_center_d = tgt_center_q;
    tgt_half_d   = tgt_half_q;
    seg_cnt_d    = seg_cnt_q;
    row_d        = row_q;

    unique case (state_q)
      StIdle: begin
        if (tick && enable) begin
          state_d = StCalc;
        end
      end
      StCalc: begin
        lfsr_step = 1'b1;
        if (seg_cnt_q == '0) begin
          tgt_center_d = TGT_CENTER_BASE + col_t'(lfsr_post[7:0]);
          tgt_half_d   = TGT_HALF_BASE + col_t'(lfsr_post[14:8]);
        end
        seg_cnt_d = (seg_cnt_q == CntW'(SEG_LEN - 1)) ? '0 : seg_cnt_q + CntW'(1);
        state_d   = StStep;
      end
      StStep: begin
        center_d = step_toward(center_q, tgt_center_q);
        half_d   = step_toward(half_q, tgt_half_q);
        state_d  = StCommit;
      end
      StCommit: begin
        row_d.left_edge    = center_q - half_q;
        row_d.island_left  = center_q - ihalf;
        row_d.island_right = center_q + ihalf;
        row_d.right_edge   = center_q + half_q;
        state_d            = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      center_q     <= RST_CENTER;
      half_q       <= RST_HALF;
      tgt_center_q <= RST_CENTER;
      tgt_half_q   <= RST_HALF;
      seg_cnt_q    <= '0;
      row_q        <= RST_ROW;
      commit_q     <= 1'b0;
      shift_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      center_q     <= center_d;
      half_q       <= half_d;
      tgt_center_q <= tgt_center_d;
      tgt_half_q   <= tgt_half_d;
      seg_cnt_q    <= seg_cnt_d;
      row_q        <= row_d;
      // Toggle one cycle after COMMIT so the row is already stable.
      commit_q     <= (state_q == StCommit);
      shift_q      <= shift_q ^ commit_q;
      overrun_q    <= overrun_q | (tick & enable & busy);
    end
  end

  assign busy    = (state_q != StIdle);
  assign shift   = shift_q;
  assign overrun = overrun_q;

  assign datain[LEFT_LSB  +: COL_W] = row_q.left_edge;
  assign datain[ISL_L_LSB +: COL_W] = row_q.island_left;
  assign datain[ISL_R_LSB +: COL_W] = row_q.island_right;
  assign datain[RIGHT_LSB +: COL_W] = row_q.right_edge;

endmodule

// File: tb/tb_boundary_gen.sv
// Scoreboard bench for boundary_gen: a reference row model queues expected rows per
// accepted tick, and a monitor pops and compares them on every shift toggle.
module tb_boundary_gen;
  import boundary_pkg::*;

  localparam int unsigned SegLen    = 32;
  localparam int unsigned IslandMin = 128;
  localparam logic [39:0] RstRow    = {10'd120, 10'd216, 10'd424, 10'd520};
  localparam logic [39:0] FirstRow  = {10'd120, 10'd216, 10'd422, 10'd518};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        tick = 1'b0;
  logic [39:0] datain;
  logic        shift;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  boundary_gen #(
    .SEG_LEN    (SegLen),
    .ISLAND_MIN (IslandMin)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (tick),
    .datain  (datain),
    .shift   (shift),
    .busy    (busy),
    .overrun (overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [15:0] m_lfsr;
  logic [9:0]  m_center, m_half, m_tc, m_th;
  int          m_seg;
  logic [39:0] exp_q[$];

  function automatic logic [15:0] ref_lfsr_next(input logic [15:0] s);
    logic fb;
    fb = ^(s & 16'h002D);
    return {fb, s[15:1]};
  endfunction

  task automatic model_reset();
    m_lfsr   = 16'hACE1;
    m_center = 10'd320;
    m_half   = 10'd200;
    m_tc     = 10'd320;
    m_th     = 10'd200;
    m_seg    = 0;
    exp_q.delete();
  endtask

  task automatic model_row();
    logic [9:0] ih;
    m_lfsr = ref_lfsr_next(m_lfsr);
    if (m_seg == 0) begin
      m_tc = 10'd192 + {2'b00, m_lfsr[7:0]};
      m_th = 10'd64 + {3'b000, m_lfsr[14:8]};
    end
    m_seg = (m_seg + 1) % SegLen;
    if (m_center < m_tc) m_center = m_center + 10'd1;
    else if (m_center > m_tc) m_center = m_center - 10'd1;
    if (m_half < m_th) m_half = m_half + 10'd1;
    else if (m_half > m_th) m_half = m_half - 10'd1;
    ih = (m_half >= IslandMin) ? (m_half - 10'd96) : 10'd0;
    exp_q.push_back({m_center - m_half, m_center - ih, m_center + ih, m_center + m_half});
  endtask

  // Monitor: every shift change must match the oldest queued row.
  logic        prev_shift;
  logic [39:0] prev_row;
  int          toggles = 0;

  always @(posedge clk) begin
    logic [39:0] e;
    int lo, hi, c_new, c_old, h_new, h_old;
    #1;
    if (!reset_n) begin
      prev_shift = shift;
      prev_row   = RstRow;
    end else if (shift !== prev_shift) begin
      toggles++;
      prev_shift = shift;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_shift", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("row", 64'(datain), 64'(e));
        lo    = int'(datain[39:30]);
        hi    = int'(datain[9:0]);
        c_new = (lo + hi) / 2;
        h_new = (hi - lo) / 2;
        c_old = (int'(prev_row[39:30]) + int'(prev_row[9:0])) / 2;
        h_old = (int'(prev_row[9:0]) - int'(prev_row[39:30])) / 2;
        check_eq("left_min", 64'(lo >= 1), 64'd1);
        check_eq("right_max", 64'(hi <= int'(SCREEN_W) - 2), 64'd1);
        check_eq("dcenter", 64'((c_new - c_old) <= 1 && (c_new - c_old) >= -1), 64'd1);
        check_eq("dhalf", 64'((h_new - h_old) <= 1 && (h_new - h_old) >= -1), 64'd1);
        prev_row = datain;
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    tick    = 1'b0;
    enable  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic send_tick(input bit en, input bit accept);
    @(negedge clk);
    tick   = 1'b1;
    enable = en;
    if (accept) model_row();
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    model_reset();
    do_reset();

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      check_eq("idle_datain", 64'(datain), 64'(RstRow));
      check_eq("idle_shift", 64'(shift), 64'd0);
      check_eq("idle_busy", 64'(busy), 64'd0);
      check_eq("idle_overrun", 64'(overrun), 64'd0);
    end

    // Single tick latency
    @(negedge clk);
    tick = 1'b1; enable = 1'b1;
    model_row();
    @(posedge clk); #1; tick = 1'b0;
    check_eq("lat_busy_t1", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check_eq("lat_busy_t2", 64'(busy), 64'd1);
    check_eq("lat_hold_t2", 64'(datain), 64'(RstRow));
    @(posedge clk); #1;
    check_eq("lat_busy_t3", 64'(busy), 64'd1);
    check_eq("lat_hold_t3", 64'(datain), 64'(RstRow));
    @(posedge clk); #1;
    check_eq("lat_row_t3", 64'(datain), 64'(FirstRow));
    check_eq("lat_model_row", 64'(datain), 64'(exp_q[0]));
    check_eq("lat_busy_idle", 64'(busy), 64'd0);
    check_eq("lat_shift_t3", 64'(shift), 64'd0);
    @(posedge clk); #1;
    check_eq("lat_shift_t4", 64'(shift), 64'd1);

    // Two full segments
    do_reset();
    base = toggles;
    for (int i = 0; i < 2 * SegLen; i++) begin
      send_tick(1'b1, 1'b1);
      repeat (6) @(negedge clk);
    end
    check_eq("seg_toggles", 64'(toggles - base), 64'(2 * SegLen));
    check_eq("seg_drain", 64'(exp_q.size()), 64'd0);
    check_eq("seg_overrun", 64'(overrun), 64'd0);

    // Tick while in STEP is dropped
    base = toggles;
    @(negedge clk); tick = 1'b1; enable = 1'b1; model_row();
    @(negedge clk); tick = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("ovr_set", 64'(overrun), 64'd1);
    check_eq("ovr_one_row", 64'(toggles - base), 64'd1);
    check_eq("ovr_drain", 64'(exp_q.size()), 64'd0);
    repeat (20) @(negedge clk);
    check_eq("ovr_sticky", 64'(overrun), 64'd1);

    // Tick coinciding with COMMIT is dropped
    do_reset();
    check_eq("ovr_reset_clear", 64'(overrun), 64'd0);
    base = toggles;
    @(negedge clk); tick = 1'b1; enable = 1'b1; model_row();
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("commit_ovr", 64'(overrun), 64'd1);
    check_eq("commit_one_row", 64'(toggles - base), 64'd1);
    check_eq("commit_drain", 64'(exp_q.size()), 64'd0);

    // Disabled tick is ignored
    do_reset();
    base = toggles;
    send_tick(1'b0, 1'b0);
    check_eq("dis_busy", 64'(busy), 64'd0);
    repeat (10) @(negedge clk);
    check_eq("dis_overrun", 64'(overrun), 64'd0);
    check_eq("dis_toggles", 64'(toggles - base), 64'd0);
    check_eq("dis_datain", 64'(datain), 64'(RstRow));

    // Enable dropped in STEP still commits
    base = toggles;
    @(negedge clk); tick = 1'b1; enable = 1'b1; model_row();
    @(negedge clk); tick = 1'b0;
    @(negedge clk); enable = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("endrop_toggles", 64'(toggles - base), 64'd1);
    check_eq("endrop_drain", 64'(exp_q.size()), 64'd0);
    check_eq("endrop_shift", 64'(shift), 64'd1);

    // Reset during STEP discards the row
    @(negedge clk); tick = 1'b1; enable = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("rst_datain", 64'(datain), 64'(RstRow));
    check_eq("rst_shift", 64'(shift), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_overrun", 64'(overrun), 64'd0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    enable  = 1'b0;
    base = toggles;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("rst_no_shift", 64'(shift), 64'd0);
    end
    check_eq("rst_toggles", 64'(toggles - base), 64'd0);
    check_eq("rst_row_kept", 64'(datain), 64'(RstRow));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
